// File: rtl/fpga_temp_monitor.sv
// fpga_temp_monitor
// Samples the synchronised die-temperature code on a fixed period, box-car
// averages 2^AVG_LOG2 samples, publishes each average, tracks the min/max of
// the published averages and raises an over-temperature alarm with hysteresis.
module fpga_temp_monitor #(
  parameter logic [15:0] SAMPLE_DIV = 16'd1000,
  parameter int          AVG_LOG2   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] temp_in,
  input  logic [11:0] hi_thresh,
  input  logic [11:0] hyst,
  input  logic        minmax_clr,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic [11:0] temp_min,
  output logic [11:0] temp_max,
  output logic        alarm,
  output logic        alarm_rise,
  output logic [15:0] avg_count
);

  localparam int          ACC_W    = 12 + AVG_LOG2;
  localparam logic [15:0] DIV_LAST = SAMPLE_DIV - 16'd1;
  localparam logic [4:0]  SMP_LAST = 5'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  logic [1:0]       state_r;
  logic [15:0]      div_cnt_r;
  logic [4:0]       smp_cnt_r;
  logic [ACC_W-1:0] acc_r;

  logic [11:0] avg_out_r;
  logic        avg_valid_r;
  logic [11:0] temp_min_r;
  logic [11:0] temp_max_r;
  logic        alarm_r;
  logic        alarm_rise_r;
  logic [15:0] avg_count_r;
  logic        reload_r;

  logic        sample_s;
  logic        publish_s;
  logic [11:0] avg_s;
  logic [11:0] lo_s;
  logic        set_s;
  logic        clr_s;

  // A sample is due on the last cycle of each period; a publish is abandoned if en drops.
  assign sample_s  = (div_cnt_r == DIV_LAST);
  assign publish_s = en && (state_r == ST_PUBLISH);

  // Truncating average; the shift consumes the whole accumulator before narrowing.
  assign avg_s = 12'(acc_r >> AVG_LOG2);

  // Clear threshold saturates at zero, which makes the alarm sticky until reset.
  assign lo_s  = (hi_thresh >= hyst) ? (hi_thresh - hyst) : 12'd0;
  assign set_s = (avg_s >= hi_thresh);
  assign clr_s = (avg_s < lo_s);

  // Sampling schedule: period divider, sample counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= 16'd0;
      smp_cnt_r <= 5'd0;
      acc_r     <= '0;
    end else if (!en) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= 16'd0;
      smp_cnt_r <= 5'd0;
      acc_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_WAIT;
          div_cnt_r <= 16'd0;
          smp_cnt_r <= 5'd0;
          acc_r     <= '0;
        end
        ST_WAIT: begin
          if (sample_s) begin
            acc_r     <= acc_r + ACC_W'(temp_in);
            div_cnt_r <= 16'd0;
            smp_cnt_r <= smp_cnt_r + 5'd1;
            if (smp_cnt_r == SMP_LAST) begin
              state_r <= ST_PUBLISH;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        ST_PUBLISH: begin
          // Divider keeps running so the sample period is not stretched.
          div_cnt_r <= div_cnt_r + 16'd1;
          smp_cnt_r <= 5'd0;
          acc_r     <= '0;
          state_r   <= ST_WAIT;
        end
        default: begin
          state_r   <= ST_IDLE;
          div_cnt_r <= 16'd0;
          smp_cnt_r <= 5'd0;
          acc_r     <= '0;
        end
      endcase
    end
  end

  // Published results: average, count, min/max tracking and alarm with hysteresis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_out_r    <= 12'd0;
      avg_valid_r  <= 1'b0;
      temp_min_r   <= 12'd0;
      temp_max_r   <= 12'd0;
      alarm_r      <= 1'b0;
      alarm_rise_r <= 1'b0;
      avg_count_r  <= 16'd0;
      reload_r     <= 1'b1;
    end else begin
      avg_valid_r  <= publish_s;
      alarm_rise_r <= publish_s && set_s && !alarm_r;
      if (publish_s) begin
        avg_out_r   <= avg_s;
        avg_count_r <= avg_count_r + 16'd1;
        reload_r    <= 1'b0;
        if (minmax_clr || reload_r) begin
          temp_min_r <= avg_s;
          temp_max_r <= avg_s;
        end else begin
          temp_min_r <= (avg_s < temp_min_r) ? avg_s : temp_min_r;
          temp_max_r <= (avg_s > temp_max_r) ? avg_s : temp_max_r;
        end
        if (set_s) begin
          alarm_r <= 1'b1;
        end else if (clr_s) begin
          alarm_r <= 1'b0;
        end else begin
          alarm_r <= alarm_r;
        end
      end else if (minmax_clr) begin
        // Arm a reload; the visible min/max hold until the next publish.
        reload_r <= 1'b1;
      end else begin
        reload_r <= reload_r;
      end
    end
  end

  assign avg_out    = avg_out_r;
  assign avg_valid  = avg_valid_r;
  assign temp_min   = temp_min_r;
  assign temp_max   = temp_max_r;
  assign alarm      = alarm_r;
  assign alarm_rise = alarm_rise_r;
  assign avg_count  = avg_count_r;

endmodule
